register_sequencer: RTL
=======================

REGISTER_SEQUENCER -- requirements
Module: register_sequencer

Interface
REQ-001 The block SHALL have these ports, one clock domain; reset is synchronous and active-high:
- input_Clock  in  1  sole clock; all state updates on rising edge.
- input_Reset  in  1  synchronous, active-high reset.
- input_Instruction  in  8  op[7:6], rs[5:4], rt[3:2], rd[1:0]; LI uses dst[5:4], imm[3:0].
- input_Instruction_Valid  in  1  producer has an instruction.
- output_Instruction_Ready  out  1  sequencer can accept.
- output_Read_Write  out  1  register-file write enable (1 = write).
- output_Read_Register1  out  2  register-file read address 1.
- output_Read_Register2  out  2  register-file read address 2.
- output_Write_Register  out  2  register-file write address.
- output_Write_Data  out  8  register-file write data.
- input_Read_Data1  in  8  register-file read data 1, combinational from address 1.
- input_Read_Data2  in  8  register-file read data 2, combinational from address 2.
- output_Print_Data  out  8  PRINT result.
- output_Print_Valid  out  1  one-cycle strobe qualifying output_Print_Data.
- output_Overflow  out  1  signed overflow of last ADD/SUB.
- output_Busy  out  1  high whenever state is not IDLE.

Function
REQ-002 Opcodes SHALL be: 00 ADD rd=rs+rt; 01 LI dst=sign-extend(imm); 10 SUB rd=rs-rt; 11 PRINT (rs to output_Print_Data).
REQ-003 FSM states SHALL be IDLE, READ, EXEC, WRITE.
REQ-004 output_Instruction_Ready SHALL be 1 only in IDLE and not in reset.
REQ-005 An instruction is accepted on an edge where Valid=1 and Ready=1; the instruction SHALL be latched in full on that edge.
REQ-006 Valid while Ready=0 SHALL be ignored; the producer holds the instruction until accepted.
REQ-007 Transitions: IDLE->READ on accepted ADD/SUB/PRINT; IDLE->WRITE on accepted LI; READ->EXEC; EXEC->WRITE for ADD/SUB; EXEC->IDLE for PRINT; WRITE->IDLE.
REQ-008 In READ, Read_Register1=rs and Read_Register2=rt; Read_Data1/2 SHALL be captured into operand registers at the end of READ.
REQ-009 In EXEC, the result SHALL be computed from the captured operands as 8-bit two's complement, wrapping modulo 256, and registered.
REQ-010 For ADD/SUB, output_Overflow SHALL update at the end of EXEC: set when operand signs (for SUB, rs sign and the inverted rt sign) match and the result sign differs, cleared otherwise. LI and PRINT SHALL NOT change it.
REQ-011 In WRITE, output_Read_Write SHALL be 1 for exactly one cycle, with Write_Register/Write_Data valid in that same cycle; Read_Write SHALL be 0 in all other states.
REQ-012 Outside WRITE, Write_Register and Write_Data SHALL be 0; Read_Register1/2 SHALL be 0 outside READ.
REQ-013 For PRINT, output_Print_Data SHALL take captured rs data and output_Print_Valid SHALL pulse for exactly one cycle, the cycle after EXEC. Print_Data SHALL hold until the next PRINT.
REQ-014 Latency from accept edge to Write cycle: ADD/SUB = 3 cycles, LI = 1 cycle. Ready SHALL reassert the cycle after WRITE, or the cycle after EXEC for PRINT.
REQ-015 Back-to-back operation: an instruction with Valid held high SHALL be accepted on the first IDLE edge, with no idle bubble beyond the IDLE cycle itself.
REQ-016 rd equal to rs or rt SHALL be legal, because operands are captured before the write.

Reset
REQ-017 On any edge with input_Reset=1, the FSM SHALL go to IDLE and clear all outputs, operand registers and the latched instruction to 0; Ready SHALL be 0 during reset and 1 in the first cycle after it.
REQ-018 Reset mid-operation, including during WRITE, SHALL abort the instruction, and Read_Write SHALL be 0 from the reset edge; no write or print pulse SHALL follow.

Verification
REQ-019 Reset, then LI 0x5B (dst=01, imm=1011) -> one-cycle write, reg 01 = 0xFB, 1 cycle after accept.
REQ-020 r1=0x35, r2=0xF0 (preloaded via LI or bench model); ADD rd=3 of r1,r2 -> write reg 3 = 0x25 (wrap), Overflow=0, 3 cycles after accept.
REQ-021 r1=0x7F, r2=0x01; ADD -> 0x80 with Overflow=1; then SUB 0x80-0x01 -> 0x7F with Overflow=1; then LI -> Overflow unchanged.
REQ-022 PRINT rs=2 with r2=0xF0 -> Print_Valid pulses for one cycle with Print_Data=0xF0; no Read_Write pulse.
REQ-023 Valid held high across ADD, LI, PRINT -> each accepted only when Ready=1; Ready low in READ/EXEC/WRITE; instruction changes while busy are ignored.
REQ-024 Reset asserted in EXEC of an ADD -> no write occurs, all outputs 0, Ready=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/register_sequencer_if.sv
// register_sequencer_if
// Bundles the instruction handshake and register-file bus of the register
// sequencer.
//   master : instruction producer plus register file. It drives the
//            instruction, valid and read data, and receives everything else.
//   slave  : the sequencer itself.
// The clock and reset are not part of this bundle; they stay plain ports on
// the sequencer.
interface register_sequencer_if;
    logic [7:0] input_Instruction;
    logic       input_Instruction_Valid;
    logic       output_Instruction_Ready;
    logic       output_Read_Write;
    logic [1:0] output_Read_Register1;
    logic [1:0] output_Read_Register2;
    logic [1:0] output_Write_Register;
    logic [7:0] output_Write_Data;
    logic [7:0] input_Read_Data1;
    logic [7:0] input_Read_Data2;
    logic [7:0] output_Print_Data;
    logic       output_Print_Valid;
    logic       output_Overflow;
    logic       output_Busy;

    modport master (
        output input_Instruction, input_Instruction_Valid,
               input_Read_Data1, input_Read_Data2,
        input  output_Instruction_Ready, output_Read_Write,
               output_Read_Register1, output_Read_Register2,
               output_Write_Register, output_Write_Data,
               output_Print_Data, output_Print_Valid,
               output_Overflow, output_Busy
    );

    modport slave (
        input  input_Instruction, input_Instruction_Valid,
               input_Read_Data1, input_Read_Data2,
        output output_Instruction_Ready, output_Read_Write,
               output_Read_Register1, output_Read_Register2,
               output_Write_Register, output_Write_Data,
               output_Print_Data, output_Print_Valid,
               output_Overflow, output_Busy
    );
endinterface

// File: rtl/register_sequencer.sv
// register_sequencer
// Takes 8-bit instructions and sequences them against an external 4x8
// register file. The supported operations are ADD, LI, SUB and PRINT.
// Ports:
//   input_Clock : the only clock. All state changes on its rising edge.
//   input_Reset : synchronous, active-high reset.
//   bus         : register_sequencer_if.slave. It carries the instruction
//                 handshake, the register-file read and write ports, the
//                 print output, the overflow flag and busy.
//
// state | meaning
// IDLE  | ready for an instruction; LI goes straight to WRITE
// READ  | drive rs/rt read addresses, capture operands at end of cycle
// EXEC  | compute the result and overflow, or launch the print
// WRITE | single-cycle register-file write of the result
module register_sequencer (
    input  logic                 input_Clock,
    input  logic                 input_Reset,
    register_sequencer_if.slave  bus
);
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_LI    = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_PRINT = 2'b11;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    state_t     state, state_next;
    logic [7:0] instr;
    logic [7:0] op_a, op_b;
    logic [7:0] result;
    logic [7:0] print_data;
    logic       print_valid;
    logic       overflow;

    logic       ready;
    logic       accept;
    logic [1:0] opcode;
    logic [7:0] sum, diff;
    logic       ovf_add, ovf_sub;

    assign opcode = instr[7:6];
    assign ready  = (state == IDLE) && !input_Reset;
    assign accept = ready && bus.input_Instruction_Valid;

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;
    // Overflow occurs when both effective operand signs agree but the
    // result sign differs. For SUB the rt sign is inverted, so the
    // equality test becomes an inequality test.
    assign ovf_add = (op_a[7] == op_b[7]) && (sum[7]  != op_a[7]);
    assign ovf_sub = (op_a[7] != op_b[7]) && (diff[7] != op_a[7]);

    always_ff @(posedge input_Clock) begin
        if (input_Reset) state <= IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.input_Instruction[7:6] == OP_LI) state_next = WRITE;
                    else                                     state_next = READ;
                end
            end
            READ:  state_next = EXEC;
            EXEC:  state_next = (opcode == OP_PRINT) ? IDLE : WRITE;
            WRITE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge input_Clock) begin
        if (input_Reset) begin
            instr       <= '0;
            op_a        <= '0;
            op_b        <= '0;
            result      <= '0;
            print_data  <= '0;
            print_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            print_valid <= 1'b0;
            if (accept) begin
                instr <= bus.input_Instruction;
                // LI skips READ/EXEC, so its sign-extended immediate is
                // loaded into the result register as it is accepted.
                if (bus.input_Instruction[7:6] == OP_LI)
                    result <= {{4{bus.input_Instruction[3]}}, bus.input_Instruction[3:0]};
            end
            if (state == READ) begin
                op_a <= bus.input_Read_Data1;
                op_b <= bus.input_Read_Data2;
            end
            if (state == EXEC) begin
                case (opcode)
                    OP_ADD: begin
                        result   <= sum;
                        overflow <= ovf_add;
                    end
                    OP_SUB: begin
                        result   <= diff;
                        overflow <= ovf_sub;
                    end
                    OP_PRINT: begin
                        print_data  <= op_a;
                        print_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.output_Read_Register1 = 2'b00;
        bus.output_Read_Register2 = 2'b00;
        bus.output_Read_Write     = 1'b0;
        bus.output_Write_Register = 2'b00;
        bus.output_Write_Data     = 8'h00;
        if (state == READ) begin
            bus.output_Read_Register1 = instr[5:4];
            bus.output_Read_Register2 = instr[3:2];
        end
        if (state == WRITE) begin
            bus.output_Read_Write     = 1'b1;
            bus.output_Write_Register = (opcode == OP_LI) ? instr[5:4] : instr[1:0];
            bus.output_Write_Data     = result;
        end
    end

    assign bus.output_Instruction_Ready = ready;
    assign bus.output_Print_Data        = print_data;
    assign bus.output_Print_Valid       = print_valid;
    assign bus.output_Overflow          = overflow;
    assign bus.output_Busy              = (state != IDLE);
endmodule
